// File: rtl/vx_smem_responder.sv
// Shared-memory responder: multi-lane word scratchpad answering reads after a fixed latency through a credit-protected FWFT queue.
// Defining SMEM_RESPONDER_PERF_EN adds read/write/stall performance counters.
module vx_smem_responder #(
    parameter int NUM_REQS       = 4,
    parameter int WORD_SIZE      = 4,
    parameter int ADDR_WIDTH     = 30,
    parameter int TAG_WIDTH      = 8,
    parameter int DEPTH          = 1024,
    parameter int LATENCY        = 2,
    parameter int RSP_QUEUE_SIZE = 4
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic [NUM_REQS-1:0]               i_req_valid,
    input  logic [NUM_REQS-1:0]               i_req_rw,
    input  logic [NUM_REQS*WORD_SIZE-1:0]     i_req_byteen,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]    i_req_addr,
    input  logic [NUM_REQS*WORD_SIZE*8-1:0]   i_req_data,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]     i_req_tag,
    output logic [NUM_REQS-1:0]               o_req_ready,
    output logic                              o_rsp_valid,
    output logic [NUM_REQS-1:0]               o_rsp_tmask,
    output logic [NUM_REQS*WORD_SIZE*8-1:0]   o_rsp_data,
    output logic [TAG_WIDTH-1:0]              o_rsp_tag,
`ifdef SMEM_RESPONDER_PERF_EN
    output logic [31:0]                       o_perf_reads,
    output logic [31:0]                       o_perf_writes,
    output logic [31:0]                       o_perf_stalls,
`endif
    input  logic                              i_rsp_ready
);

    localparam int DW    = WORD_SIZE * 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W = (RSP_QUEUE_SIZE > 1) ? $clog2(RSP_QUEUE_SIZE) : 1;
    localparam int CRD_W = $clog2(RSP_QUEUE_SIZE) + 1;

    logic [DW-1:0]             r_mem [DEPTH];

    logic [NUM_REQS-1:0]       w_rd_mask;
    logic [NUM_REQS-1:0]       w_wr_mask;
    logic [IDX_W-1:0]          w_idx [NUM_REQS];
    logic [NUM_REQS*DW-1:0]    w_rd_data;
    logic [TAG_WIDTH-1:0]      w_first_tag;
    logic                      w_ready;
    logic                      w_accept;
    logic                      w_take;
    logic                      w_pop;
    logic                      w_unused_addr;

    logic                      w_push_valid;
    logic [NUM_REQS-1:0]       w_push_tmask;
    logic [NUM_REQS*DW-1:0]    w_push_data;
    logic [TAG_WIDTH-1:0]      w_push_tag;

    logic [NUM_REQS-1:0]       r_q_tmask [RSP_QUEUE_SIZE];
    logic [NUM_REQS*DW-1:0]    r_q_data  [RSP_QUEUE_SIZE];
    logic [TAG_WIDTH-1:0]      r_q_tag   [RSP_QUEUE_SIZE];
    logic [PTR_W-1:0]          r_wptr;
    logic [PTR_W-1:0]          r_rptr;
    logic [CRD_W-1:0]          r_q_count;
    logic [CRD_W-1:0]          r_credits;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_QUEUE_SIZE - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_rd_mask     = i_req_valid & ~i_req_rw;
    assign w_wr_mask     = i_req_valid & i_req_rw;
    assign w_ready       = i_reset && (r_credits < CRD_W'(RSP_QUEUE_SIZE));
    assign w_accept      = (|i_req_valid) && w_ready;
    assign w_take        = w_accept && (|w_rd_mask);
    assign w_pop         = o_rsp_valid && i_rsp_ready;
    assign w_unused_addr = ^i_req_addr;
    assign o_req_ready   = {NUM_REQS{w_ready}};

    // Upper address bits are ignored, so addresses alias modulo DEPTH.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQS; gi++) begin : g_lane
            assign w_idx[gi] = i_req_addr[gi*ADDR_WIDTH +: IDX_W];
            assign w_rd_data[gi*DW +: DW] = w_rd_mask[gi] ? r_mem[w_idx[gi]] : '0;
        end
    endgenerate

    always_comb begin
        w_first_tag = i_req_tag[TAG_WIDTH-1:0];
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (i_req_valid[i]) begin
                w_first_tag = i_req_tag[i*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    // Later lanes overwrite earlier ones byte by byte, so the highest lane wins.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NUM_REQS; i++) begin
            for (int b = 0; b < WORD_SIZE; b++) begin
                if (w_accept && w_wr_mask[i] && i_req_byteen[i*WORD_SIZE + b]) begin
                    r_mem[w_idx[i]][b*8 +: 8] <= i_req_data[(i*WORD_SIZE + b)*8 +: 8];
                end
            end
        end
    end

    generate
        if (LATENCY == 1) begin : g_nopipe
            assign w_push_valid = w_take;
            assign w_push_tmask = w_rd_mask;
            assign w_push_data  = w_rd_data;
            assign w_push_tag   = w_first_tag;
        end else begin : g_pipe
            localparam int STAGES = LATENCY - 1;
            logic [STAGES-1:0]      r_pipe_valid;
            logic [NUM_REQS-1:0]    r_pipe_tmask [STAGES];
            logic [NUM_REQS*DW-1:0] r_pipe_data  [STAGES];
            logic [TAG_WIDTH-1:0]   r_pipe_tag   [STAGES];

            always_ff @(posedge i_clk) begin
                if (!i_reset) begin
                    r_pipe_valid <= '0;
                end else begin
                    r_pipe_valid[0] <= w_take;
                    for (int s = 1; s < STAGES; s++) begin
                        r_pipe_valid[s] <= r_pipe_valid[s-1];
                    end
                end
            end

            // Stage 0 captures the pre-write array contents at the acceptance edge.
            always_ff @(posedge i_clk) begin
                r_pipe_tmask[0] <= w_rd_mask;
                r_pipe_data[0]  <= w_rd_data;
                r_pipe_tag[0]   <= w_first_tag;
                for (int s = 1; s < STAGES; s++) begin
                    r_pipe_tmask[s] <= r_pipe_tmask[s-1];
                    r_pipe_data[s]  <= r_pipe_data[s-1];
                    r_pipe_tag[s]   <= r_pipe_tag[s-1];
                end
            end

            assign w_push_valid = r_pipe_valid[STAGES-1];
            assign w_push_tmask = r_pipe_tmask[STAGES-1];
            assign w_push_data  = r_pipe_data[STAGES-1];
            assign w_push_tag   = r_pipe_tag[STAGES-1];
        end
    endgenerate

    // No full check on push: a credit is held for every response in flight.
    always_ff @(posedge i_clk) begin
        if (w_push_valid) begin
            r_q_tmask[r_wptr] <= w_push_tmask;
            r_q_data[r_wptr]  <= w_push_data;
            r_q_tag[r_wptr]   <= w_push_tag;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_q_count <= '0;
            r_credits <= '0;
        end else begin
            if (w_push_valid) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push_valid, w_pop})
                2'b10:   r_q_count <= r_q_count + 1'b1;
                2'b01:   r_q_count <= r_q_count - 1'b1;
                default: r_q_count <= r_q_count;
            endcase
            case ({w_take, w_pop})
                2'b10:   r_credits <= r_credits + 1'b1;
                2'b01:   r_credits <= r_credits - 1'b1;
                default: r_credits <= r_credits;
            endcase
        end
    end

    assign o_rsp_valid = (r_q_count != '0);
    assign o_rsp_tmask = r_q_tmask[r_rptr];
    assign o_rsp_data  = r_q_data[r_rptr];
    assign o_rsp_tag   = r_q_tag[r_rptr];

`ifdef SMEM_RESPONDER_PERF_EN
    localparam int CNT_W = $clog2(NUM_REQS + 1);
    logic [CNT_W-1:0] w_rd_cnt;
    logic [CNT_W-1:0] w_wr_cnt;
    logic [31:0]      r_perf_reads;
    logic [31:0]      r_perf_writes;
    logic [31:0]      r_perf_stalls;

    always_comb begin
        w_rd_cnt = '0;
        w_wr_cnt = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            w_rd_cnt = w_rd_cnt + CNT_W'(w_rd_mask[i]);
            w_wr_cnt = w_wr_cnt + CNT_W'(w_wr_mask[i]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_perf_reads  <= '0;
            r_perf_writes <= '0;
            r_perf_stalls <= '0;
        end else begin
            if (w_accept) begin
                r_perf_reads  <= r_perf_reads + 32'(w_rd_cnt);
                r_perf_writes <= r_perf_writes + 32'(w_wr_cnt);
            end
            if ((|i_req_valid) && !w_ready) begin
                r_perf_stalls <= r_perf_stalls + 1'b1;
            end
        end
    end

    assign o_perf_reads  = r_perf_reads;
    assign o_perf_writes = r_perf_writes;
    assign o_perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_vx_smem_responder.sv
// Randomized and directed bench for vx_smem_responder against a queue/array reference model.
module tb_vx_smem_responder;

    localparam int N     = 4;
    localparam int WS    = 4;
    localparam int AW    = 30;
    localparam int TW    = 8;
    localparam int DEPTH = 1024;
    localparam int IW    = 10;
    localparam int LAT   = 2;
    localparam int QS    = 4;
    localparam int DW    = WS * 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_rw = '0;
    logic [N*WS-1:0]   req_byteen = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N*TW-1:0]   req_tag = '0;
    logic              rsp_ready = 1'b1;
    logic [N-1:0]      o_req_ready;
    logic              o_rsp_valid;
    logic [N-1:0]      o_rsp_tmask;
    logic [N*DW-1:0]   o_rsp_data;
    logic [TW-1:0]     o_rsp_tag;

    vx_smem_responder #(
        .NUM_REQS(N), .WORD_SIZE(WS), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
        .DEPTH(DEPTH), .LATENCY(LAT), .RSP_QUEUE_SIZE(QS)
    ) dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_req_valid(req_valid), .i_req_rw(req_rw), .i_req_byteen(req_byteen),
        .i_req_addr(req_addr), .i_req_data(req_data), .i_req_tag(req_tag),
        .o_req_ready(o_req_ready), .o_rsp_valid(o_rsp_valid), .o_rsp_tmask(o_rsp_tmask),
        .o_rsp_data(o_rsp_data), .o_rsp_tag(o_rsp_tag), .i_rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              due;
        logic [N-1:0]    tmask;
        logic [N*DW-1:0] data;
        logic [TW-1:0]   tag;
    } rsp_t;

    rsp_t          rq[$];
    logic [DW-1:0] mmem [DEPTH];
    int            cyc = 0;
    bit            inited = 1'b0;
    int            total = 0;
    int            bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: responses become visible LAT cycles after the accepting cycle, in order.
    always @(negedge clk) begin
        bit   exp_ready;
        bit   exp_valid;
        rsp_t r;
        exp_ready = rst_n && (rq.size() < QS);
        exp_valid = (rq.size() > 0) && (rq[0].due <= cyc);
        if (inited) begin
            chk("req_ready", 128'(o_req_ready), 128'({N{exp_ready}}));
            chk("rsp_valid", 128'(o_rsp_valid), 128'(exp_valid));
            if (exp_valid) begin
                chk("rsp_tmask", 128'(o_rsp_tmask), 128'(rq[0].tmask));
                chk("rsp_data", 128'(o_rsp_data), 128'(rq[0].data));
                chk("rsp_tag", 128'(o_rsp_tag), 128'(rq[0].tag));
            end
        end
        if (!rst_n) begin
            rq.delete();
            inited = 1'b1;
        end else if (inited) begin
            if (exp_valid && rsp_ready) begin
                void'(rq.pop_front());
            end
            if ((|req_valid) && exp_ready) begin
                r.due   = cyc + LAT;
                r.tmask = req_valid & ~req_rw;
                r.data  = '0;
                r.tag   = '0;
                for (int i = N - 1; i >= 0; i--) begin
                    if (req_valid[i]) r.tag = req_tag[i*TW +: TW];
                end
                for (int i = 0; i < N; i++) begin
                    if (r.tmask[i]) r.data[i*DW +: DW] = mmem[req_addr[i*AW +: IW]];
                end
                if (|r.tmask) rq.push_back(r);
                for (int i = 0; i < N; i++) begin
                    for (int b = 0; b < WS; b++) begin
                        if (req_valid[i] && req_rw[i] && req_byteen[i*WS + b]) begin
                            mmem[req_addr[i*AW +: IW]][b*8 +: 8] = req_data[(i*WS + b)*8 +: 8];
                        end
                    end
                end
            end
        end
        cyc++;
    end

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] rw, input logic [N*WS-1:0] be,
                         input logic [N*AW-1:0] a, input logic [N*DW-1:0] d, input logic [N*TW-1:0] t);
        req_valid  = v;
        req_rw     = rw;
        req_byteen = be;
        req_addr   = a;
        req_data   = d;
        req_tag    = t;
    endtask

    // Holds a batch until it is accepted; called and returns just after a rising edge.
    task automatic send(input logic [N-1:0] v, input logic [N-1:0] rw, input logic [N*WS-1:0] be,
                        input logic [N*AW-1:0] a, input logic [N*DW-1:0] d, input logic [N*TW-1:0] t);
        bit acc;
        int n;
        drive(v, rw, be, a, d, t);
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = o_req_ready[0];
            @(posedge clk);
            #1;
            n++;
        end
        req_valid = '0;
        if (!acc) chk("send_accept_timeout", 128'(0), 128'(1));
    endtask

    task automatic get_rsp(output int lat, output logic [N-1:0] tm, output logic [N*DW-1:0] d,
                           output logic [TW-1:0] tg);
        lat = 0;
        tm  = '0;
        d   = '0;
        tg  = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (o_rsp_valid) begin
                lat = k;
                tm  = o_rsp_tmask;
                d   = o_rsp_data;
                tg  = o_rsp_tag;
                break;
            end
        end
        if (lat == 0) chk("rsp_timeout", 128'(0), 128'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int              lat;
        int              acc;
        logic [N-1:0]    tm;
        logic [N*DW-1:0] d;
        logic [TW-1:0]   tg;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int k = 0; k < DEPTH / N; k++) begin
            send('1, '1, '1, {30'(4*k + 3), 30'(4*k + 2), 30'(4*k + 1), 30'(4*k)},
                 {$urandom, $urandom, $urandom, $urandom}, '0);
        end

        send(4'b0001, 4'b0001, 16'h000F, {30'd0, 30'd0, 30'd0, 30'd5}, {96'd0, 32'hDEADBEEF}, '0);
        send(4'b1111, 4'b0000, 16'h0000, {30'd8, 30'd7, 30'd6, 30'd5}, '0, {8'h44, 8'h33, 8'h22, 8'h3C});
        get_rsp(lat, tm, d, tg);
        chk("t1_latency", 128'(lat), 128'(2));
        chk("t1_tmask", 128'(tm), 128'(4'b1111));
        chk("t1_lane0", 128'(d[31:0]), 128'(32'hDEADBEEF));
        chk("t1_tag", 128'(tg), 128'(8'h3C));

        send(4'b1010, 4'b1010, 16'h30F0, {30'd9, 30'd0, 30'd9, 30'd0},
             {32'h22222222, 32'h0, 32'h11111111, 32'h0}, '0);
        send(4'b0001, 4'b0000, 16'h0, {90'd0, 30'd9}, '0, {24'd0, 8'h09});
        get_rsp(lat, tm, d, tg);
        chk("t2_merge", 128'(d[31:0]), 128'(32'h11112222));

        send(4'b0001, 4'b0001, 16'h000F, {90'd0, 30'd2}, {96'd0, 32'h5}, '0);
        send(4'b0011, 4'b0001, 16'h000F, {60'd0, 30'd2, 30'd2}, {64'd0, 32'h0, 32'hAAAA0000},
             {16'd0, 8'h77, 8'h5A});
        get_rsp(lat, tm, d, tg);
        chk("t3_tmask", 128'(tm), 128'(4'b0010));
        chk("t3_data", 128'(d), {64'd0, 32'h5, 32'h0});
        chk("t3_tag", 128'(tg), 128'(8'h5A));
        send(4'b0001, 4'b0000, 16'h0, {90'd0, 30'd2}, '0, '0);
        get_rsp(lat, tm, d, tg);
        chk("t3_after", 128'(d[31:0]), 128'(32'hAAAA0000));

        send(4'b0001, 4'b0001, 16'h000F, {90'd0, 30'h400}, {96'd0, 32'h12345678}, '0);
        send(4'b0001, 4'b0000, 16'h0, {90'd0, 30'h0}, '0, '0);
        get_rsp(lat, tm, d, tg);
        chk("t4_alias", 128'(d[31:0]), 128'(32'h12345678));

        rsp_ready = 1'b0;
        acc = 0;
        for (int k = 1; k <= 6; k++) begin
            drive(4'b0001, 4'b0000, '0, {90'd0, 30'(k)}, '0, {24'd0, 8'(k)});
            @(negedge clk);
            if (o_req_ready[0]) acc++;
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        chk("bp_accepted", 128'(acc), 128'(4));
        @(negedge clk);
        chk("bp_ready_low", 128'(o_req_ready), 128'(0));
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("bp_order", 128'({o_rsp_valid, o_rsp_tag}), 128'({1'b1, 8'(k)}));
        end
        @(posedge clk);
        #1;
        send(4'b0001, 4'b0000, '0, {90'd0, 30'd5}, '0, {24'd0, 8'd5});
        send(4'b0001, 4'b0000, '0, {90'd0, 30'd6}, '0, {24'd0, 8'd6});
        get_rsp(lat, tm, d, tg);
        chk("bp_late5", 128'(tg), 128'(8'd5));
        get_rsp(lat, tm, d, tg);
        chk("bp_late6", 128'(tg), 128'(8'd6));

        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send(4'b0001, 4'b0000, '0, {90'd0, 30'd2}, '0, {24'd0, 8'(8'hA1 + k)});
        end
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_valid", 128'(o_rsp_valid), 128'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_ready_low", 128'(o_req_ready), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rsp_valid", 128'(o_rsp_valid), 128'(0));
        chk("rst_ready_high", 128'(o_req_ready), 128'(4'hF));
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        send(4'b0001, 4'b0000, '0, {90'd0, 30'd2}, '0, {24'd0, 8'hB0});
        get_rsp(lat, tm, d, tg);
        chk("rst_retained", 128'({tg, d[31:0]}), 128'({8'hB0, 32'hAAAA0000}));

        for (int it = 0; it < 1500; it++) begin
            rst_n      = ($urandom_range(0, 299) != 0);
            rsp_ready  = ($urandom_range(0, 3) != 0);
            req_valid  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            req_rw     = N'($urandom);
            req_byteen = (N*WS)'($urandom);
            for (int i = 0; i < N; i++) begin
                req_addr[i*AW +: AW] = AW'($urandom & 32'h3FFF_FC0F);
                req_data[i*DW +: DW] = $urandom;
                req_tag[i*TW +: TW]  = TW'($urandom);
            end
            @(posedge clk);
            #1;
        end
        rst_n     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vx_smem_responder.md
Name: vx_smem_responder

Overview:
- Responder end of the per-lane dcache request/response protocol. It plays the memory side that an execute-stage initiator (LSU or texture unit) drives.
- Serves multi-lane word requests from a local scratchpad array. Returns read data with a fixed pipeline latency through a credit-protected response queue.
- Used as the shared-memory target behind the dcache request arbiter, and as a self-checking memory model in unit benches.

Parameters:
- NUM_REQS, 4: number of lanes (threads) per request batch.
- WORD_SIZE, 4: bytes per lane word.
- ADDR_WIDTH, 30: word address width per lane.
- TAG_WIDTH, 8: request/response tag width.
- DEPTH, 1024: words in the array; power of two.
- LATENCY, 2: cycles from acceptance to rsp_valid when the queue is empty; must be ≥1.
- RSP_QUEUE_SIZE, 4: response queue entries; power of two, ≥LATENCY.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQS  per-lane request valid.
- req_rw  in  NUM_REQS  per-lane: 1=write, 0=read.
- req_byteen  in  NUM_REQS*WORD_SIZE  per-lane byte enables (writes only).
- req_addr  in  NUM_REQS*ADDR_WIDTH  per-lane word address.
- req_data  in  NUM_REQS*WORD_SIZE*8  per-lane write data.
- req_tag  in  NUM_REQS*TAG_WIDTH  per-lane tag.
- req_ready  out  NUM_REQS  per-lane ready; all bits are identical.
- rsp_valid  out  1  response valid.
- rsp_tmask  out  NUM_REQS  lanes carrying read data.
- rsp_data  out  NUM_REQS*WORD_SIZE*8  per-lane read data.
- rsp_tag  out  TAG_WIDTH  response tag.
- rsp_ready  in  1  response consumer ready.

Behaviour:
- Reset (reset==0 at a clk edge):
  - Pipeline valids, queue pointers and credit counter clear to 0.
  - rsp_valid=0, and req_ready=0 while reset is low.
  - Array contents are not cleared.
  - A reset mid-operation drops all in-flight and queued responses.
- Batch acceptance:
  - A batch is accepted in any cycle where |req_valid && req_ready.
  - All valid lanes are accepted together; there is no partial acceptance.
  - req_ready = reset && (credits < RSP_QUEUE_SIZE). It is combinational from registered state only and does not depend on req_valid.
- Credits:
  - A credit is taken at acceptance only if the batch has ≥1 read lane (valid & ~rw).
  - A credit is returned when rsp_valid && rsp_ready.
  - Take and return in the same cycle: the count is unchanged.
  - Credit width is clog2(RSP_QUEUE_SIZE)+1.
- Indexing: the array is indexed by req_addr[i][clog2(DEPTH)-1:0]; upper bits are ignored, so addresses alias.
- Writes:
  - Committed at the acceptance edge, per byte, under byteen.
  - Several lanes writing the same index: the highest lane index wins per byte.
  - Write-only batches produce no response.
- Reads:
  - The array is read at the acceptance edge.
  - Read lanes see pre-batch data; a write in the same batch is not visible.
  - A read in a later batch sees the earlier write.
- Response word:
  - rsp_tmask = valid & ~rw.
  - rsp_data lanes outside tmask are 0.
  - rsp_tag = req_tag of the lowest-indexed valid lane of the batch, including write lanes.
- Pipeline and queue:
  - The response word passes through LATENCY-1 further register stages into a first-word-fall-through queue.
  - Pipeline stages never stall; credits guarantee queue space.
  - Responses leave in acceptance order.
  - Back-to-back read batches with rsp_ready=1 sustain one response per cycle.
- Queue boundaries: pointers wrap modulo RSP_QUEUE_SIZE. Full queue plus a pending credit means req_ready stays 0 until a pop.
- Output stability: rsp_valid, rsp_tmask, rsp_data and rsp_tag hold stable while rsp_valid && !rsp_ready.

Optional Feature:
SMEM_RESPONDER_PERF_EN:
- When defined, adds three outputs, each cleared by reset and wrapping at 2^32:
  - perf_reads (32): counts accepted read lanes.
  - perf_writes (32): counts accepted write lanes.
  - perf_stalls (32): counts cycles with |req_valid && !req_ready.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Write lane0 addr 5 data 0xDEADBEEF byteen 4'b1111, then read lanes0-3 addrs 5,6,7,8 tag 0x3C -> LATENCY=2 cycles after read acceptance: rsp_valid=1, tmask 4'b1111, lane0=0xDEADBEEF, tag 0x3C; no response for the write.
- Lanes 1 and 3 write addr 9 with 0x11111111 / 0x22222222 and byteen 1111 / 0011, then read addr 9 -> 0x11112222.
- Batch with lane0 write 0xAAAA0000 to addr 2 and lane1 read addr 2 (old value 0x5) -> tmask 4'b0010, lane1=0x5, tag from lane0; a subsequent read of addr 2 returns 0xAAAA0000.
- rsp_ready=0, issue 6 read batches -> exactly 4 accepted, req_ready=0 after the 4th; raise rsp_ready -> 4 responses in order, then the remaining 2 are accepted.
- Address aliasing, DEPTH=1024: write addr 0x400, read addr 0 -> returns the written data.
- Pull reset low for 1 cycle with 3 responses queued -> rsp_valid=0 next cycle, credits 0, req_ready=1 after release; array data is retained (re-read matches). With SMEM_RESPONDER_PERF_EN defined, counters read 0 after reset.
